// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle data-memory access engine for the MIPS CPU.
// Latches one load/store request, runs a single Avalon-style bus transaction
// with waitrequest stalls and a stall timeout, then pulses o_done with the
// extended load result.
// Optional build macro ALIGN_TRAP_EN: misaligned half/word accesses complete
// immediately with o_err=1 and never reach the bus.
module load_store_unit #(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [5:0]  i_opcode,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_store_data,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [31:0] o_load_data,
  output logic [31:0] o_mem_address,
  output logic        o_mem_read,
  output logic        o_mem_write,
  output logic [3:0]  o_mem_byteenable,
  output logic [31:0] o_mem_writedata,
  input  logic [31:0] i_mem_readdata,
  input  logic        i_mem_waitrequest
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCESS = 2'd1, S_DONE = 2'd2} state_t;

  // Last stall count before the timeout fires on the next stalled edge.
  localparam logic [15:0] LP_LAST_WAIT = 16'(WAIT_LIMIT - 1);

  function automatic logic op_valid(input logic [5:0] op);
    case (op)
      6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101,
      6'b101000, 6'b101001, 6'b101011: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

  // size: 2'b00 byte, 2'b01 half, 2'b11 word (opcode[1:0]).
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   return 4'b0001 << a;
      2'b01:   return 4'b0011 << {a[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] wr_data(input logic [1:0] size, input logic [31:0] rt);
    case (size)
      2'b00:   return {4{rt[7:0]}};
      2'b01:   return {2{rt[15:0]}};
      default: return rt;
    endcase
  endfunction

  function automatic logic [31:0] extract(input logic uns, input logic [1:0] size,
                                          input logic [1:0] a, input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'b00:   b = rd[7:0];
      2'b01:   b = rd[15:8];
      2'b10:   b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = a[1] ? rd[31:16] : rd[15:0];
    case (size)
      2'b00:   return uns ? {24'h000000, b} : {{24{b[7]}}, b};
      2'b01:   return uns ? {16'h0000, h} : {{16{h[15]}}, h};
      default: return rd;
    endcase
  endfunction

`ifdef ALIGN_TRAP_EN
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b01:   return a[0];
      2'b11:   return (a != 2'b00);
      default: return 1'b0;
    endcase
  endfunction
`endif

  state_t      r_state, w_state;
  logic        r_is_store, w_is_store;
  logic        r_unsigned, w_unsigned;
  logic [1:0]  r_size, w_size;
  logic [1:0]  r_addr_lo, w_addr_lo;
  logic [15:0] r_wait_cnt, w_wait_cnt;
  logic        r_busy, w_busy;
  logic        r_done, w_done;
  logic        r_err, w_err;
  logic [31:0] r_load_data, w_load_data;
  logic [31:0] r_mem_address, w_mem_address;
  logic        r_mem_read, w_mem_read;
  logic        r_mem_write, w_mem_write;
  logic [3:0]  r_mem_be, w_mem_be;
  logic [31:0] r_mem_wdata, w_mem_wdata;

  // Next-state and next-output logic; every register holds unless a branch overrides it.
  always_comb begin
    w_state       = r_state;
    w_is_store    = r_is_store;
    w_unsigned    = r_unsigned;
    w_size        = r_size;
    w_addr_lo     = r_addr_lo;
    w_wait_cnt    = r_wait_cnt;
    w_busy        = r_busy;
    w_done        = 1'b0;
    w_err         = r_err;
    w_load_data   = r_load_data;
    w_mem_address = r_mem_address;
    w_mem_read    = r_mem_read;
    w_mem_write   = r_mem_write;
    w_mem_be      = r_mem_be;
    w_mem_wdata   = r_mem_wdata;
    case (r_state)
      S_IDLE: begin
        if (i_start && op_valid(i_opcode)) begin
          w_is_store    = i_opcode[3];
          w_unsigned    = i_opcode[2];
          w_size        = i_opcode[1:0];
          w_addr_lo     = i_addr[1:0];
          w_wait_cnt    = 16'd0;
          w_busy        = 1'b1;
          w_err         = 1'b0;
          w_mem_address = {i_addr[31:2], 2'b00};
          w_mem_be      = byte_en(i_opcode[1:0], i_addr[1:0]);
          w_mem_wdata   = wr_data(i_opcode[1:0], i_store_data);
`ifdef ALIGN_TRAP_EN
          if (misaligned(i_opcode[1:0], i_addr[1:0])) begin
            // Trap: skip the bus entirely and report the error next cycle.
            w_state     = S_DONE;
            w_done      = 1'b1;
            w_err       = 1'b1;
            w_load_data = 32'h0000_0000;
          end else begin
            w_state     = S_ACCESS;
            w_mem_read  = ~i_opcode[3];
            w_mem_write = i_opcode[3];
          end
`else
          w_state     = S_ACCESS;
          w_mem_read  = ~i_opcode[3];
          w_mem_write = i_opcode[3];
`endif
        end else begin
          w_state = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (!i_mem_waitrequest) begin
          w_state     = S_DONE;
          w_done      = 1'b1;
          w_err       = 1'b0;
          w_mem_read  = 1'b0;
          w_mem_write = 1'b0;
          if (!r_is_store) begin
            w_load_data = extract(r_unsigned, r_size, r_addr_lo, i_mem_readdata);
          end else begin
            w_load_data = r_load_data;
          end
        end else if (r_wait_cnt == LP_LAST_WAIT) begin
          // Stall budget exhausted: abandon the cycle and report an error.
          w_wait_cnt  = r_wait_cnt + 16'd1;
          w_state     = S_DONE;
          w_done      = 1'b1;
          w_err       = 1'b1;
          w_load_data = 32'h0000_0000;
          w_mem_read  = 1'b0;
          w_mem_write = 1'b0;
        end else begin
          w_wait_cnt = r_wait_cnt + 16'd1;
        end
      end
      S_DONE: begin
        w_state = S_IDLE;
        w_busy  = 1'b0;
        w_err   = 1'b0;
      end
      default: begin
        w_state     = S_IDLE;
        w_busy      = 1'b0;
        w_err       = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_is_store    <= 1'b0;
      r_unsigned    <= 1'b0;
      r_size        <= 2'b00;
      r_addr_lo     <= 2'b00;
      r_wait_cnt    <= 16'd0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_load_data   <= 32'h0000_0000;
      r_mem_address <= 32'h0000_0000;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_be      <= 4'b0000;
      r_mem_wdata   <= 32'h0000_0000;
    end else begin
      r_state       <= w_state;
      r_is_store    <= w_is_store;
      r_unsigned    <= w_unsigned;
      r_size        <= w_size;
      r_addr_lo     <= w_addr_lo;
      r_wait_cnt    <= w_wait_cnt;
      r_busy        <= w_busy;
      r_done        <= w_done;
      r_err         <= w_err;
      r_load_data   <= w_load_data;
      r_mem_address <= w_mem_address;
      r_mem_read    <= w_mem_read;
      r_mem_write   <= w_mem_write;
      r_mem_be      <= w_mem_be;
      r_mem_wdata   <= w_mem_wdata;
    end
  end

  assign o_busy           = r_busy;
  assign o_done           = r_done;
  assign o_err            = r_err;
  assign o_load_data      = r_load_data;
  assign o_mem_address    = r_mem_address;
  assign o_mem_read       = r_mem_read;
  assign o_mem_write      = r_mem_write;
  assign o_mem_byteenable = r_mem_be;
  assign o_mem_writedata  = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: the driver queues the expected bus
// cycle and completion for each request; a negedge monitor checks them when
// the strobe rises and when o_done pulses. Built with WAIT_LIMIT=4.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  opcode;
  logic [31:0] addr, store_data;
  logic        busy, done, err;
  logic [31:0] load_data, mem_address, mem_writedata, mem_readdata;
  logic        mem_read, mem_write, mem_waitrequest;
  logic [3:0]  mem_byteenable;

  localparam logic [5:0] OP_LB = 6'b100000, OP_LH = 6'b100001, OP_LW = 6'b100011,
                         OP_LBU = 6'b100100, OP_LHU = 6'b100101,
                         OP_SB = 6'b101000, OP_SH = 6'b101001, OP_SW = 6'b101011;

  load_store_unit #(.WAIT_LIMIT(4)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_opcode(opcode), .i_addr(addr),
    .i_store_data(store_data), .o_busy(busy), .o_done(done), .o_err(err),
    .o_load_data(load_data), .o_mem_address(mem_address), .o_mem_read(mem_read),
    .o_mem_write(mem_write), .o_mem_byteenable(mem_byteenable),
    .o_mem_writedata(mem_writedata), .i_mem_readdata(mem_readdata),
    .i_mem_waitrequest(mem_waitrequest)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        err;
    logic [31:0] data;
    int          done_cyc;
    int          strobes;
  } resp_t;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        is_store;
  } bus_t;

  resp_t resp_q[$];
  bus_t  bus_q[$];
  int    n_checks = 0;
  int    n_pass = 0;
  int    cyc = 0;
  int    stall_cycles = 0;
  int    stall_cnt = 0;
  int    strobe_cnt = 0;
  logic  strobe_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else n_pass++;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Bus slave model: stall each strobe for stall_cycles cycles, then accept.
  always @(negedge clk) begin
    if ((mem_read || mem_write) && stall_cnt < stall_cycles) begin
      mem_waitrequest = 1'b1;
      stall_cnt++;
    end else begin
      mem_waitrequest = 1'b0;
      if (!(mem_read || mem_write)) stall_cnt = 0;
    end
  end

  // Monitor: checks bus cycles as they start and completions as they pulse.
  always @(negedge clk) begin
    bus_t  b;
    resp_t r;
    if (reset) begin
      strobe_cnt  = 0;
      strobe_prev = 1'b0;
    end else begin
      if (mem_read || mem_write) begin
        strobe_cnt++;
        if (!strobe_prev) begin
          if (bus_q.size() == 0) begin
            check("unexpected_strobe", 32'd1, 32'd0);
          end else begin
            b = bus_q.pop_front();
            check({b.name, "_addr"}, mem_address, b.addr);
            check({b.name, "_be"}, {28'd0, mem_byteenable}, {28'd0, b.be});
            check({b.name, "_dir"}, {30'd0, mem_write, mem_read}, {30'd0, b.is_store, ~b.is_store});
            if (b.is_store) check({b.name, "_wdata"}, mem_writedata, b.wdata);
          end
        end
      end
      strobe_prev = mem_read || mem_write;
      if (done) begin
        if (resp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          r = resp_q.pop_front();
          check({r.name, "_err"}, {31'd0, err}, {31'd0, r.err});
          check({r.name, "_data"}, load_data, r.data);
          check({r.name, "_done_cyc"}, cyc, r.done_cyc);
          check({r.name, "_strobes"}, strobe_cnt, r.strobes);
        end
        strobe_cnt = 0;
      end
    end
  end

  // Issue one request and wait (bounded) for the unit to go idle again.
  task automatic do_op(input string name, input logic [5:0] op, input logic [31:0] a,
                       input logic [31:0] rt, input logic [31:0] rd, input int stalls,
                       input logic e_err, input logic [31:0] e_data, input int lat,
                       input int strobes, input logic [31:0] e_addr, input logic [3:0] e_be,
                       input logic [31:0] e_wdata);
    resp_t r;
    bus_t  b;
    int    k;
    @(negedge clk);
    opcode       = op;
    addr         = a;
    store_data   = rt;
    mem_readdata = rd;
    stall_cycles = stalls;
    start        = 1'b1;
    r = '{name: name, err: e_err, data: e_data, done_cyc: cyc + lat, strobes: strobes};
    resp_q.push_back(r);
    if (strobes > 0) begin
      b = '{name: name, addr: e_addr, be: e_be, wdata: e_wdata, is_store: op[3]};
      bus_q.push_back(b);
    end
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while ((busy || done) && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (k >= 40) check({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  initial begin
    int k;
    reset = 1'b1; start = 1'b0; opcode = 6'd0; addr = 32'd0; store_data = 32'd0;
    mem_readdata = 32'd0; mem_waitrequest = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_load_data", load_data, 32'd0);
    check("rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    check("rst_be", {28'd0, mem_byteenable}, 32'd0);
    check("rst_addr", mem_address, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    do_op("lw", OP_LW, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1'b0, 32'hDEADBEEF, 2, 1, 32'h100, 4'b1111, 32'h0);
    do_op("lb", OP_LB, 32'h103, 32'h0, 32'h80112233, 0, 1'b0, 32'hFFFFFF80, 2, 1, 32'h100, 4'b1000, 32'h0);
    do_op("lbu", OP_LBU, 32'h103, 32'h0, 32'h80112233, 0, 1'b0, 32'h00000080, 2, 1, 32'h100, 4'b1000, 32'h0);
    do_op("sh", OP_SH, 32'h206, 32'h1234ABCD, 32'hFFFFFFFF, 0, 1'b0, 32'h00000080, 2, 1, 32'h204, 4'b1100, 32'hABCDABCD);
    do_op("lh", OP_LH, 32'h102, 32'h0, 32'h80112233, 0, 1'b0, 32'hFFFF8011, 2, 1, 32'h100, 4'b1100, 32'h0);
    do_op("lhu", OP_LHU, 32'h100, 32'h0, 32'h80112233, 0, 1'b0, 32'h00002233, 2, 1, 32'h100, 4'b0011, 32'h0);
    do_op("lb_pos", OP_LB, 32'h101, 32'h0, 32'h80112233, 0, 1'b0, 32'h00000022, 2, 1, 32'h100, 4'b0010, 32'h0);
    do_op("sb", OP_SB, 32'h101, 32'h000000A5, 32'h0, 0, 1'b0, 32'h00000022, 2, 1, 32'h100, 4'b0010, 32'hA5A5A5A5);
    do_op("sw", OP_SW, 32'h10C, 32'hCAFEF00D, 32'h0, 0, 1'b0, 32'h00000022, 2, 1, 32'h10C, 4'b1111, 32'hCAFEF00D);

    // Unlisted opcode: no transaction, stays idle.
    @(negedge clk);
    opcode = 6'b100010; addr = 32'h40; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("bad_op_busy", {31'd0, busy}, 32'd0);
    check("bad_op_strobe", {30'd0, mem_read, mem_write}, 32'd0);

    // Three stalls (one below the limit), with a stray start while busy that must be ignored.
    fork
      do_op("lw_stall3", OP_LW, 32'h300, 32'h0, 32'h01234567, 3, 1'b0, 32'h01234567, 5, 4, 32'h300, 4'b1111, 32'h0);
      begin
        repeat (3) @(negedge clk);
        opcode = OP_SW; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join

    // Stuck waitrequest: abort after 4 stall cycles.
    do_op("lw_timeout", OP_LW, 32'h304, 32'h0, 32'h11111111, 100, 1'b1, 32'h00000000, 5, 4, 32'h304, 4'b1111, 32'h0);

    // Reset in the middle of an access: strobe drops, no done.
    @(negedge clk);
    opcode = OP_LW; addr = 32'h500; mem_readdata = 32'h77777777; stall_cycles = 100; start = 1'b1;
    bus_q.push_back('{name: "lw_rst", addr: 32'h500, be: 4'b1111, wdata: 32'h0, is_store: 1'b0});
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("pre_rst_strobe", {31'd0, mem_read}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_strobe", {30'd0, mem_read, mem_write}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mid_no_done", {31'd0, done}, 32'd0);

    do_op("lw_after_rst", OP_LW, 32'h104, 32'h0, 32'h55AA55AA, 0, 1'b0, 32'h55AA55AA, 2, 1, 32'h104, 4'b1111, 32'h0);

`ifdef ALIGN_TRAP_EN
    do_op("lw_misalign", OP_LW, 32'h102, 32'h0, 32'h12345678, 0, 1'b1, 32'h00000000, 1, 0, 32'h0, 4'b0000, 32'h0);
    do_op("lh_misalign", OP_LH, 32'h103, 32'h0, 32'h12345678, 0, 1'b1, 32'h00000000, 1, 0, 32'h0, 4'b0000, 32'h0);
`else
    do_op("lw_unaligned", OP_LW, 32'h102, 32'h0, 32'h12345678, 0, 1'b0, 32'h12345678, 2, 1, 32'h100, 4'b1111, 32'h0);
    do_op("lh_unaligned", OP_LH, 32'h103, 32'h0, 32'h9ABC5678, 0, 1'b0, 32'hFFFF9ABC, 2, 1, 32'h100, 4'b1100, 32'h0);
`endif

    k = 0;
    repeat (3) @(negedge clk);
    check("resp_q_empty", resp_q.size(), 32'd0);
    check("bus_q_empty", bus_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
